// File: rtl/timer_pkg.sv
// Shared register map, CON bit layout and mode encoding for the timer bank.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package timer_pkg;

  // Per-channel register offsets within a 16-byte channel slot
  localparam logic [3:0]  OFF_TH      = 4'h0;
  localparam logic [3:0]  OFF_TL      = 4'h4;
  localparam logic [3:0]  OFF_CON     = 4'h8;
  // Systick lives past the channel slots, relative to the window base
  localparam logic [31:0] OFF_SYSTICK = 32'h0000_0100;

  // CON register layout
  localparam int CON_W    = 4;
  localparam int CON_EN   = 0;
  localparam int CON_IEN  = 1;
  localparam int CON_STS  = 2;
  localparam int CON_MODE = 3;

  typedef enum logic {
    MODE_ONESHOT  = 1'b0,
    MODE_PERIODIC = 1'b1
  } mode_e;

  // Field order matches the CON bit positions above (MSB first)
  typedef struct packed {
    mode_e mode;
    logic  sts;
    logic  ien;
    logic  en;
  } con_t;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: TH reload, TL up-counter, CON control/status, overflow detect.
// Latency: register writes and counting take effect at the next rising edge; irq_req is combinational from state.
// Backpressure: none; a write is accepted every cycle it is strobed.
module timer_channel
  import timer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_th,
  input  logic             wr_tl,
  input  logic             wr_con,
  input  logic [WIDTH-1:0] wdata,
  input  logic [CON_W-1:0] wcon,
  output logic [WIDTH-1:0] th,
  output logic [WIDTH-1:0] tl,
  output logic [CON_W-1:0] con,
  output logic             irq_req
);

  localparam logic [WIDTH-1:0] TL_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] TL_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  con_t con_q;
  logic ovf;

  // A bus write to TL in the overflow cycle cancels that overflow entirely:
  // no reload, no STS set, no one-shot disable.
  assign ovf     = con_q.en && (tl == TL_MAX) && !wr_tl;
  assign con     = con_q;
  assign irq_req = con_q.sts & con_q.ien;

  // Reload value; only sampled into TL at the next overflow
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      th <= '0;
    else if (wr_th) th <= wdata;
  end

  // Count register: bus write beats reload beats increment
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         tl <= '0;
    else if (wr_tl)    tl <= wdata;
    else if (ovf)      tl <= th;
    else if (con_q.en) tl <= tl + TL_ONE;
  end

  // Control bits follow bus writes; STS set by overflow wins over a W1C clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      con_q <= '0;
    end else begin
      if (wr_con) begin
        con_q.en   <= wcon[CON_EN];
        con_q.ien  <= wcon[CON_IEN];
        con_q.mode <= mode_e'(wcon[CON_MODE]);
      end else if (ovf && con_q.mode == MODE_ONESHOT) begin
        con_q.en   <= 1'b0;
      end
      if (ovf)                         con_q.sts <= 1'b1;
      else if (wr_con && wcon[CON_STS]) con_q.sts <= 1'b0;
    end
  end

endmodule

// File: rtl/timer_bank.sv
// Bank of N_CH memory-mapped timers plus a free-running Systick, with a shared level irq.
// Latency: reads combinational in the MemRead cycle; writes land on the next rising edge.
// Backpressure: none; one read and/or one write accepted every cycle.
module timer_bank
  import timer_pkg::*;
#(
  parameter int          N_CH      = 2,
  parameter int          WIDTH     = 32,
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  output logic [31:0] Read_data,
  output logic        irq,
  output logic [31:0] Systick
);

  logic [31:0]      off;
  logic [27:0]      ch_idx;
  logic [3:0]       reg_off;
  logic             sys_hit;
  logic             unused_addr_lsb;
  logic [WIDTH-1:0] th_q  [N_CH];
  logic [WIDTH-1:0] tl_q  [N_CH];
  logic [CON_W-1:0] con_q [N_CH];
  logic [N_CH-1:0]  irq_v;

  // Decode relative to the window base; byte-lane bits are ignored
  assign off             = Address - BASE_ADDR;
  assign ch_idx          = off[31:4];
  assign reg_off         = {off[3:2], 2'b00};
  assign sys_hit         = ({off[31:2], 2'b00} == OFF_SYSTICK);
  assign unused_addr_lsb = ^off[1:0];

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic sel;
    assign sel = MemWrite && (ch_idx == 28'(c));

    timer_channel #(.WIDTH(WIDTH)) u_ch (
      .clk     (clk),
      .reset   (reset),
      .wr_th   (sel && (reg_off == OFF_TH)),
      .wr_tl   (sel && (reg_off == OFF_TL)),
      .wr_con  (sel && (reg_off == OFF_CON)),
      .wdata   (Write_data[WIDTH-1:0]),
      .wcon    (Write_data[CON_W-1:0]),
      .th      (th_q[c]),
      .tl      (tl_q[c]),
      .con     (con_q[c]),
      .irq_req (irq_v[c])
    );
  end

  // Read mux: zero unless strobed and mapped; registers are zero-extended
  always_comb begin
    Read_data = '0;
    if (MemRead) begin
      if (sys_hit) Read_data = Systick;
      for (int c = 0; c < N_CH; c++) begin
        if (ch_idx == 28'(c)) begin
          case (reg_off)
            OFF_TH:  Read_data[WIDTH-1:0] = th_q[c];
            OFF_TL:  Read_data[WIDTH-1:0] = tl_q[c];
            OFF_CON: Read_data[CON_W-1:0] = con_q[c];
            default: ;
          endcase
        end
      end
    end
  end

  // Free-running cycle counter, wraps naturally at 2^32
  always_ff @(posedge clk or posedge reset) begin
    if (reset) Systick <= '0;
    else       Systick <= Systick + 32'd1;
  end

  assign irq = |irq_v;

endmodule
